// File: rtl/alu_pkg.sv
// Shared ALU opcodes, datapath widths and issuer FSM states.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADDC  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd6;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR   = 4'd8;
  localparam logic [OP_W-1:0] OP_SHL   = 4'd9;
  localparam logic [OP_W-1:0] OP_MAX   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

  // Opcodes beyond the defined set are flagged as errors.
  function automatic logic op_is_err(input logic [OP_W-1:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/alu_issuer_fifo.sv
// Two-entry result FIFO; head is presented combinationally from storage.
module alu_issuer_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid_c,
  output logic             o_full_c,
  output logic [WIDTH-1:0] o_head_c
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_valid_c = (r_count != 2'd0);
  assign o_full_c  = (r_count == 2'd2);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_pop     = i_pop & o_valid_c;
  assign w_push    = i_push & (~o_full_c | w_pop);

  // Storage, pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one command at a time to an external combinational ALU and queues
// tagged results. Optional zero flag per result: ALU_ISSUER_ZFLAG_EN.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
`ifdef ALU_ISSUER_ZFLAG_EN
  ,
  output logic              rsp_zero
`endif
);

`ifdef ALU_ISSUER_ZFLAG_EN
  localparam int unsigned ENTRY_W = DATA_W + TAG_W + 2;
`else
  localparam int unsigned ENTRY_W = DATA_W + TAG_W + 1;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic [TAG_W-1:0]    r_tag;
  logic                w_accept;
  logic                w_push;
  logic                w_fifo_valid;
  logic                w_fifo_full;
  logic [ENTRY_W-1:0]  w_push_data;
  logic [ENTRY_W-1:0]  w_head;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept, one settle cycle, then capture.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_CAPT;
      ST_CAPT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE with FIFO room, push in CAPT.
  always_comb begin
    cmd_ready = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = ~w_fifo_full & ~rst;
      ST_CAPT: w_push    = 1'b1;
      default: ;
    endcase
    w_accept = cmd_valid & cmd_ready;
  end

  // ALU operand/opcode registers, held from accept until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_alu_a  <= cmd_a;
      r_alu_b  <= cmd_b;
      r_alu_op <= cmd_op;
    end
  end

  // Sequence tag advances on every captured result, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tag <= '0;
    else if (w_push) r_tag <= r_tag + TAG_W'(1);
  end

`ifdef ALU_ISSUER_ZFLAG_EN
  assign w_push_data = {alu_res, r_tag, op_is_err(r_alu_op), (alu_res == DATA_W'(0))};
  assign {rsp_data, rsp_tag, rsp_err, rsp_zero} = w_head;
`else
  assign w_push_data = {alu_res, r_tag, op_is_err(r_alu_op)};
  assign {rsp_data, rsp_tag, rsp_err} = w_head;
`endif

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = w_fifo_valid;

  alu_issuer_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (rsp_ready),
    .o_valid_c   (w_fifo_valid),
    .o_full_c    (w_fifo_full),
    .o_head_c    (w_head)
  );

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural 8-bit ALU.
module tb_alu_op_issuer;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic [7:0]       alu_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
`ifdef ALU_ISSUER_ZFLAG_EN
  logic             rsp_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural ALU; undefined opcodes return all-ones.
  always_comb begin
    case (alu_op)
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a & alu_b;
      4'd3:    alu_res = alu_a | alu_b;
      4'd4:    alu_res = alu_a ^ alu_b;
      4'd5:    alu_res = ~alu_a;
      4'd6:    alu_res = alu_a;
      4'd7:    alu_res = alu_b;
      4'd8:    alu_res = alu_a >> 1;
      4'd9:    alu_res = alu_a << 1;
      default: alu_res = 8'hFF;
    endcase
  end

  alu_op_issuer #(
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
`ifdef ALU_ISSUER_ZFLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulse reset for one cycle; caller sits on a falling edge.
  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for cmd_ready, then offer one command for one edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Check the head entry, then pop it.
  task automatic pop_check(input logic [7:0] data, input logic [3:0] tag, input logic err);
    chk("pop_valid", 32'(rsp_valid), 32'd1);
    chk("pop_data", 32'(rsp_data), 32'(data));
    chk("pop_tag", 32'(rsp_tag), 32'(tag));
    chk("pop_err", 32'(rsp_err), 32'(err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_err=%0d)", n_err);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // AND F0 & 3C: latency and registered operands.
    send(4'd2, 8'hF0, 8'h3C);
    chk("exec_alu_a", 32'(alu_a), 32'hF0);
    chk("exec_alu_b", 32'(alu_b), 32'h3C);
    chk("exec_alu_op", 32'(alu_op), 32'd2);
    chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("lat_n0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_n1_valid", 32'(rsp_valid), 32'd0);
    chk("capt_alu_a", 32'(alu_a), 32'hF0);
    @(negedge clk);
    pop_check(8'h30, 4'd0, 1'b0);
    chk("after_pop_valid", 32'(rsp_valid), 32'd0);

    // Undefined opcode 4'b1100: all-ones result with error flag.
    send(4'hC, 8'h12, 8'h34);
    repeat (2) @(negedge clk);
    pop_check(8'hFF, 4'd1, 1'b1);

    // Back-pressure: two accepted, third stalls until a pop.
    do_reset();
    send(4'd0, 8'h01, 8'h02);
    send(4'd1, 8'h09, 8'h04);
    repeat (2) @(negedge clk);
    cmd_op    = 4'd3;
    cmd_a     = 8'h10;
    cmd_b     = 8'h01;
    cmd_valid = 1'b1;
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("full_cmd_ready_hold", 32'(cmd_ready), 32'd0);
    chk("hold_tag", 32'(rsp_tag), 32'd0);
    chk("hold_data", 32'(rsp_data), 32'h03);
    pop_check(8'h03, 4'd0, 1'b0);
    chk("room_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("third_exec_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    pop_check(8'h05, 4'd1, 1'b0);
    pop_check(8'h11, 4'd2, 1'b0);
    chk("drained_valid", 32'(rsp_valid), 32'd0);

    // Tag wrap over 17 commands.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(4'd6, 8'(i + 8'h40), 8'h00);
      repeat (2) @(negedge clk);
      chk("wrap_valid", 32'(rsp_valid), 32'd1);
      chk("wrap_tag", 32'(rsp_tag), 32'(i % 16));
      chk("wrap_data", 32'(rsp_data), 32'(i + 8'h40));
    end
    @(negedge clk);
    chk("wrap_drained", 32'(rsp_valid), 32'd0);

    // Reset during EXEC discards the command and restarts tags.
    do_reset();
    rsp_ready = 1'b1;
    send(4'd6, 8'hAA, 8'h00);
    repeat (2) @(negedge clk);
    chk("pre_rst_tag", 32'(rsp_tag), 32'd0);
    send(4'd6, 8'hBB, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_valid", 32'(rsp_valid), 32'd0);
    send(4'd3, 8'h0F, 8'hF0);
    repeat (2) @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_tag", 32'(rsp_tag), 32'd0);
    chk("post_rst_data", 32'(rsp_data), 32'hFF);
    chk("post_rst_err", 32'(rsp_err), 32'd0);

`ifdef ALU_ISSUER_ZFLAG_EN
    // Zero flag: 55 ^ 55 = 0, then a nonzero result.
    do_reset();
    send(4'd4, 8'h55, 8'h55);
    repeat (2) @(negedge clk);
    chk("zf_data", 32'(rsp_data), 32'd0);
    chk("zf_zero", 32'(rsp_zero), 32'd1);
    pop_check(8'h00, 4'd0, 1'b0);
    send(4'd4, 8'h55, 8'h54);
    repeat (2) @(negedge clk);
    chk("zf_nz_zero", 32'(rsp_zero), 32'd0);
    pop_check(8'h01, 4'd1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
